// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bundle for the RV32I execute stage: the stage sees the ID/EX fields,
// hazard controls and write-back value, and drives the redirect and the EX/MEM register.
interface ex_stage_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_ex;
  logic [XLEN-1:0] pc_ex;
  logic [XLEN-1:0] pc_plus_4_ex;
  logic [XLEN-1:0] rs1_data_ex;
  logic [XLEN-1:0] rs2_data_ex;
  logic [XLEN-1:0] immediate_ex;
  logic [4:0]      rd_ex;
  logic [2:0]      func_3_ex;
  logic            func_7_bit_6_ex;
  logic            im_to_rf_ex;
  logic            store_ex;
  logic            load_ex;
  logic            branch_ex;
  logic [1:0]      alu_operand_a_selector_ex;
  logic            alu_operand_b_selector_ex;
  logic [1:0]      alu_operations_selector_ex;
  logic [1:0]      next_pc_selector_ex;
  logic [1:0]      forward_a_sel;
  logic [1:0]      forward_b_sel;
  logic [XLEN-1:0] wb_data;
  logic            stall_mem;
  logic            flush_mem;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            valid_mem;
  logic [XLEN-1:0] alu_result_mem;
  logic [XLEN-1:0] store_data_mem;
  logic [XLEN-1:0] pc_plus_4_mem;
  logic [4:0]      rd_mem;
  logic [2:0]      func_3_mem;
  logic            im_to_rf_mem;
  logic            store_mem;
  logic            load_mem;

  modport slave (
    input  valid_ex, pc_ex, pc_plus_4_ex, rs1_data_ex, rs2_data_ex, immediate_ex,
           rd_ex, func_3_ex, func_7_bit_6_ex, im_to_rf_ex, store_ex, load_ex,
           branch_ex, alu_operand_a_selector_ex, alu_operand_b_selector_ex,
           alu_operations_selector_ex, next_pc_selector_ex, forward_a_sel,
           forward_b_sel, wb_data, stall_mem, flush_mem,
    output redirect_valid, redirect_pc, valid_mem, alu_result_mem, store_data_mem,
           pc_plus_4_mem, rd_mem, func_3_mem, im_to_rf_mem, store_mem, load_mem
  );

  modport master (
    output valid_ex, pc_ex, pc_plus_4_ex, rs1_data_ex, rs2_data_ex, immediate_ex,
           rd_ex, func_3_ex, func_7_bit_6_ex, im_to_rf_ex, store_ex, load_ex,
           branch_ex, alu_operand_a_selector_ex, alu_operand_b_selector_ex,
           alu_operations_selector_ex, next_pc_selector_ex, forward_a_sel,
           forward_b_sel, wb_data, stall_mem, flush_mem,
    input  redirect_valid, redirect_pc, valid_mem, alu_result_mem, store_data_mem,
           pc_plus_4_mem, rd_mem, func_3_mem, im_to_rf_mem, store_mem, load_mem
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution with a
// combinational PC redirect, and the EX/MEM pipeline register.
module ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  ex_stage_if.slave bus
);

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] sum_ab;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] result;
  logic            cmp_true;
  logic            is_link;
  logic            take;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] jalr_sum;
  logic            redirect;

  logic            valid_q;
  logic [XLEN-1:0] alu_q;
  logic [XLEN-1:0] store_data_q;
  logic [XLEN-1:0] pc_plus_4_q;
  logic [4:0]      rd_q;
  logic [2:0]      func_3_q;
  logic            im_to_rf_q;
  logic            store_q;
  logic            load_q;

  // forwarding sources: the EX/MEM result from last cycle and the MEM/WB value
  always_comb begin
    case (bus.forward_a_sel)
      2'b01:   fwd_rs1 = alu_q;
      2'b10:   fwd_rs1 = bus.wb_data;
      default: fwd_rs1 = bus.rs1_data_ex;
    endcase
    case (bus.forward_b_sel)
      2'b01:   fwd_rs2 = alu_q;
      2'b10:   fwd_rs2 = bus.wb_data;
      default: fwd_rs2 = bus.rs2_data_ex;
    endcase
  end

  always_comb begin
    case (bus.alu_operand_a_selector_ex)
      2'b00:   op_a = fwd_rs1;
      2'b01:   op_a = bus.pc_ex;
      default: op_a = '0;
    endcase
    op_b = bus.alu_operand_b_selector_ex ? bus.immediate_ex : fwd_rs2;
  end

  assign sum_ab = op_a + op_b;
  assign shamt  = op_b[4:0];

  always_comb begin
    alu_out = sum_ab;
    if (bus.alu_operations_selector_ex[1]) begin
      case (bus.func_3_ex)
        3'b000: alu_out = (!bus.alu_operations_selector_ex[0] && bus.func_7_bit_6_ex)
                          ? op_a - op_b : sum_ab;
        3'b001: alu_out = op_a << shamt;
        3'b010: alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
        3'b011: alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
        3'b100: alu_out = op_a ^ op_b;
        3'b101: alu_out = bus.func_7_bit_6_ex ? $unsigned($signed(op_a) >>> shamt)
                                              : op_a >> shamt;
        3'b110: alu_out = op_a | op_b;
        default: alu_out = op_a & op_b;
      endcase
    end
  end

  // branch conditions always compare the forwarded registers, never the ALU operands
  always_comb begin
    case (bus.func_3_ex)
      3'b000:  cmp_true = (fwd_rs1 == fwd_rs2);
      3'b001:  cmp_true = (fwd_rs1 != fwd_rs2);
      3'b100:  cmp_true = ($signed(fwd_rs1) < $signed(fwd_rs2));
      3'b101:  cmp_true = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      3'b110:  cmp_true = (fwd_rs1 < fwd_rs2);
      3'b111:  cmp_true = (fwd_rs1 >= fwd_rs2);
      default: cmp_true = 1'b0;
    endcase
  end

  assign jalr_sum = fwd_rs1 + bus.immediate_ex;
  assign is_link  = bus.next_pc_selector_ex[1];

  always_comb begin
    take   = 1'b0;
    target = bus.pc_ex + bus.immediate_ex;
    case (bus.next_pc_selector_ex)
      2'b01: take = bus.branch_ex & cmp_true;
      2'b10: take = 1'b1;
      2'b11: begin
        take   = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end
      default: take = 1'b0;
    endcase
  end

  // a stalled instruction stays in EX, so it redirects only on its final cycle
  assign redirect           = !rst && bus.valid_ex && !bus.stall_mem && take;
  assign bus.redirect_valid = redirect;
  assign bus.redirect_pc    = redirect ? target : bus.pc_plus_4_ex;

  assign result = is_link ? bus.pc_plus_4_ex : alu_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      alu_q        <= '0;
      store_data_q <= '0;
      pc_plus_4_q  <= '0;
      rd_q         <= '0;
      func_3_q     <= '0;
      im_to_rf_q   <= 1'b0;
      store_q      <= 1'b0;
      load_q       <= 1'b0;
    end else if (bus.flush_mem) begin
      valid_q    <= 1'b0;
      im_to_rf_q <= 1'b0;
      store_q    <= 1'b0;
      load_q     <= 1'b0;
    end else if (!bus.stall_mem) begin
      valid_q      <= bus.valid_ex;
      alu_q        <= result;
      store_data_q <= fwd_rs2;
      pc_plus_4_q  <= bus.pc_plus_4_ex;
      rd_q         <= bus.rd_ex;
      func_3_q     <= bus.func_3_ex;
      im_to_rf_q   <= bus.valid_ex & bus.im_to_rf_ex;
      store_q      <= bus.valid_ex & bus.store_ex;
      load_q       <= bus.valid_ex & bus.load_ex;
    end
  end

  assign bus.valid_mem      = valid_q;
  assign bus.alu_result_mem = alu_q;
  assign bus.store_data_mem = store_data_q;
  assign bus.pc_plus_4_mem  = pc_plus_4_q;
  assign bus.rd_mem         = rd_q;
  assign bus.func_3_mem     = func_3_q;
  assign bus.im_to_rf_mem   = im_to_rf_q;
  assign bus.store_mem      = store_q;
  assign bus.load_mem       = load_q;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: stimulus pushes hand-computed expectations into
// queues; two monitors pop and compare redirect (before the edge) and EX/MEM (after it).
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if #(.XLEN(32)) bus ();

  ex_stage #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          id;
    logic        rv;
    logic [31:0] rpc;
    logic [3:0]  ctl;   // {valid, im_to_rf, store, load}
    logic [31:0] alu;
    logic [31:0] sd;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [2:0]  f3;
  } exp_t;

  exp_t rq[$];
  exp_t mq[$];
  int total = 0;
  int bad   = 0;
  int step  = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s step%0d got=%h want=%h", name, id, act, want);
    end
  endtask

  function automatic exp_t mk(input logic rv, input logic [31:0] rpc, input logic [3:0] ctl,
                              input logic [31:0] alu, input logic [31:0] sd,
                              input logic [31:0] pc4, input logic [4:0] rd,
                              input logic [2:0] f3);
    exp_t e;
    e.id = 0; e.rv = rv; e.rpc = rpc; e.ctl = ctl; e.alu = alu;
    e.sd = sd; e.pc4 = pc4; e.rd = rd; e.f3 = f3;
    return e;
  endfunction

  task automatic issue(input exp_t e);
    e.id = step;
    step++;
    rq.push_back(e);
    mq.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    rst = 1'b0;
    bus.valid_ex = 1'b1;
    bus.pc_ex = '0; bus.pc_plus_4_ex = '0;
    bus.rs1_data_ex = '0; bus.rs2_data_ex = '0; bus.immediate_ex = '0;
    bus.rd_ex = '0; bus.func_3_ex = '0; bus.func_7_bit_6_ex = 1'b0;
    bus.im_to_rf_ex = 1'b0; bus.store_ex = 1'b0; bus.load_ex = 1'b0; bus.branch_ex = 1'b0;
    bus.alu_operand_a_selector_ex = 2'b00; bus.alu_operand_b_selector_ex = 1'b0;
    bus.alu_operations_selector_ex = 2'b00; bus.next_pc_selector_ex = 2'b00;
    bus.forward_a_sel = 2'b00; bus.forward_b_sel = 2'b00;
    bus.wb_data = '0; bus.stall_mem = 1'b0; bus.flush_mem = 1'b0;
  endtask

  // redirect is combinational: sample mid-cycle, after inputs settled
  initial begin
    forever begin
      @(negedge clk);
      if (rq.size() > 0) begin
        exp_t e;
        e = rq.pop_front();
        chk("redirect_valid", e.id, {31'b0, bus.redirect_valid}, {31'b0, e.rv});
        chk("redirect_pc", e.id, bus.redirect_pc, e.rpc);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mq.size() > 0) begin
        exp_t e;
        e = mq.pop_front();
        chk("ctl_mem", e.id,
            {28'b0, bus.valid_mem, bus.im_to_rf_mem, bus.store_mem, bus.load_mem},
            {28'b0, e.ctl});
        chk("alu_result_mem", e.id, bus.alu_result_mem, e.alu);
        chk("store_data_mem", e.id, bus.store_data_mem, e.sd);
        chk("pc_plus_4_mem", e.id, bus.pc_plus_4_mem, e.pc4);
        chk("rd_mem", e.id, {27'b0, bus.rd_mem}, {27'b0, e.rd});
        chk("func_3_mem", e.id, {29'b0, bus.func_3_mem}, {29'b0, e.f3});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog step%0d got=timeout want=finish", step);
    $fatal(1, "timeout");
  end

  task automatic rtype(input logic [2:0] f3, input logic f7, input logic [31:0] want);
    idle();
    bus.im_to_rf_ex = 1'b1; bus.rs1_data_ex = 32'hFFFF_FFF0; bus.rs2_data_ex = 32'h4;
    bus.rd_ex = 5'd5; bus.pc_ex = 32'h20; bus.pc_plus_4_ex = 32'h24;
    bus.alu_operations_selector_ex = 2'b10; bus.func_3_ex = f3; bus.func_7_bit_6_ex = f7;
    issue(mk(1'b0, 32'h24, 4'b1100, want, 32'h4, 32'h24, 5'd5, f3));
  endtask

  task automatic branch(input logic [2:0] f3, input logic [31:0] r1, input logic [31:0] r2,
                        input logic rv, input logic [31:0] rpc, input logic [31:0] sum);
    idle();
    bus.branch_ex = 1'b1; bus.next_pc_selector_ex = 2'b01; bus.alu_operations_selector_ex = 2'b01;
    bus.pc_ex = 32'h40; bus.pc_plus_4_ex = 32'h44; bus.immediate_ex = 32'h10;
    bus.func_3_ex = f3; bus.rs1_data_ex = r1; bus.rs2_data_ex = r2;
    issue(mk(rv, rpc, 4'b1000, sum, r2, 32'h44, 5'd0, f3));
  endtask

  initial begin
    idle();
    @(posedge clk);
    #2;

    // reset state, with a jal pending to prove redirect is suppressed
    idle(); rst = 1'b1; bus.next_pc_selector_ex = 2'b10; bus.immediate_ex = 32'h100;
    issue(mk(1'b0, 32'h0, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0));

    idle(); bus.im_to_rf_ex = 1'b1; bus.rs1_data_ex = 32'd5; bus.rs2_data_ex = 32'd7;
    bus.rd_ex = 5'd3; bus.pc_ex = 32'h10; bus.pc_plus_4_ex = 32'h14;
    bus.alu_operations_selector_ex = 2'b10;
    issue(mk(1'b0, 32'h14, 4'b1100, 32'hC, 32'h7, 32'h14, 5'd3, 3'd0));

    // reset beats stall
    rst = 1'b1; bus.stall_mem = 1'b1; bus.next_pc_selector_ex = 2'b10; bus.immediate_ex = 32'h100;
    issue(mk(1'b0, 32'h14, 4'b0000, 32'h0, 32'h0, 32'h0, 5'd0, 3'd0));

    rtype(3'b000, 1'b1, 32'hFFFF_FFEC);
    rtype(3'b001, 1'b0, 32'hFFFF_FF00);
    rtype(3'b010, 1'b0, 32'h1);
    rtype(3'b011, 1'b0, 32'h0);
    rtype(3'b100, 1'b0, 32'hFFFF_FFF4);
    rtype(3'b101, 1'b0, 32'h0FFF_FFFF);
    rtype(3'b101, 1'b1, 32'hFFFF_FFFF);
    rtype(3'b110, 1'b0, 32'hFFFF_FFF4);
    rtype(3'b111, 1'b0, 32'h0);

    // I-type: funct7 bit ignored for add; shift amount from imm[4:0] only
    idle(); bus.im_to_rf_ex = 1'b1; bus.rs1_data_ex = 32'hFFFF_FFF0; bus.rs2_data_ex = 32'h4;
    bus.rd_ex = 5'd5; bus.pc_ex = 32'h20; bus.pc_plus_4_ex = 32'h24;
    bus.alu_operations_selector_ex = 2'b11; bus.alu_operand_b_selector_ex = 1'b1;
    bus.func_7_bit_6_ex = 1'b1; bus.immediate_ex = 32'h20;
    issue(mk(1'b0, 32'h24, 4'b1100, 32'h10, 32'h4, 32'h24, 5'd5, 3'd0));
    bus.func_3_ex = 3'b101; bus.immediate_ex = 32'h404;
    issue(mk(1'b0, 32'h24, 4'b1100, 32'hFFFF_FFFF, 32'h4, 32'h24, 5'd5, 3'd5));

    // forwarding
    idle(); bus.im_to_rf_ex = 1'b1; bus.rs1_data_ex = 32'h80; bus.rs2_data_ex = 32'h80;
    bus.rd_ex = 5'd1; bus.pc_ex = 32'h30; bus.pc_plus_4_ex = 32'h34;
    issue(mk(1'b0, 32'h34, 4'b1100, 32'h100, 32'h80, 32'h34, 5'd1, 3'd0));
    idle(); bus.im_to_rf_ex = 1'b1; bus.rs1_data_ex = 32'h1; bus.rs2_data_ex = 32'h999;
    bus.forward_a_sel = 2'b01; bus.forward_b_sel = 2'b10; bus.wb_data = 32'h20;
    bus.rd_ex = 5'd2; bus.pc_ex = 32'h34; bus.pc_plus_4_ex = 32'h38;
    issue(mk(1'b0, 32'h38, 4'b1100, 32'h120, 32'h20, 32'h38, 5'd2, 3'd0));
    idle(); bus.store_ex = 1'b1; bus.rs1_data_ex = 32'h1; bus.rs2_data_ex = 32'h999;
    bus.forward_a_sel = 2'b01; bus.forward_b_sel = 2'b10; bus.wb_data = 32'h20;
    bus.alu_operand_b_selector_ex = 1'b1; bus.immediate_ex = 32'h8; bus.func_3_ex = 3'b010;
    bus.pc_ex = 32'h38; bus.pc_plus_4_ex = 32'h3C;
    issue(mk(1'b0, 32'h3C, 4'b1010, 32'h128, 32'h20, 32'h3C, 5'd0, 3'd2));
    idle(); bus.im_to_rf_ex = 1'b1; bus.rs1_data_ex = 32'h3; bus.rs2_data_ex = 32'h4;
    bus.forward_a_sel = 2'b11; bus.forward_b_sel = 2'b11; bus.wb_data = 32'h55;
    bus.rd_ex = 5'd4; bus.pc_ex = 32'h3C; bus.pc_plus_4_ex = 32'h40;
    issue(mk(1'b0, 32'h40, 4'b1100, 32'h7, 32'h4, 32'h40, 5'd4, 3'd0));

    // branches at pc=0x40, imm=0x10
    branch(3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h50, 32'h0);
    branch(3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h44, 32'h0);
    branch(3'b001, 32'h7, 32'h7, 1'b0, 32'h44, 32'hE);
    branch(3'b000, 32'h7, 32'h7, 1'b1, 32'h50, 32'hE);
    branch(3'b111, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h50, 32'h0);
    branch(3'b101, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h44, 32'h0);
    branch(3'b010, 32'h7, 32'h7, 1'b0, 32'h44, 32'hE);

    // jalr held by stall: no redirect, EX/MEM keeps the previous branch
    idle(); bus.im_to_rf_ex = 1'b1; bus.rd_ex = 5'd1; bus.pc_ex = 32'h80; bus.pc_plus_4_ex = 32'h84;
    bus.rs1_data_ex = 32'h1003; bus.immediate_ex = 32'h4; bus.alu_operand_b_selector_ex = 1'b1;
    bus.next_pc_selector_ex = 2'b11; bus.stall_mem = 1'b1;
    issue(mk(1'b0, 32'h84, 4'b1000, 32'hE, 32'h7, 32'h44, 5'd0, 3'd2));
    bus.stall_mem = 1'b0;
    issue(mk(1'b1, 32'h1006, 4'b1100, 32'h84, 32'h0, 32'h84, 5'd1, 3'd0));

    idle(); bus.im_to_rf_ex = 1'b1; bus.rd_ex = 5'd1; bus.pc_ex = 32'h100; bus.pc_plus_4_ex = 32'h104;
    bus.immediate_ex = 32'h7FC; bus.alu_operand_a_selector_ex = 2'b01;
    bus.alu_operand_b_selector_ex = 1'b1; bus.next_pc_selector_ex = 2'b10;
    issue(mk(1'b1, 32'h8FC, 4'b1100, 32'h104, 32'h0, 32'h104, 5'd1, 3'd0));

    // flush beats stall: control bits clear, data fields hold
    idle(); bus.load_ex = 1'b1; bus.im_to_rf_ex = 1'b1; bus.rd_ex = 5'd6; bus.func_3_ex = 3'b010;
    bus.rs1_data_ex = 32'h200; bus.immediate_ex = 32'h8; bus.alu_operand_b_selector_ex = 1'b1;
    bus.pc_ex = 32'h110; bus.pc_plus_4_ex = 32'h114; bus.flush_mem = 1'b1; bus.stall_mem = 1'b1;
    issue(mk(1'b0, 32'h114, 4'b0000, 32'h104, 32'h0, 32'h104, 5'd1, 3'd0));
    bus.flush_mem = 1'b0; bus.stall_mem = 1'b0;
    issue(mk(1'b0, 32'h114, 4'b1101, 32'h208, 32'h0, 32'h114, 5'd6, 3'd2));

    // bubble with a taken beq: no redirect, invalid slot captured
    idle(); bus.valid_ex = 1'b0; bus.im_to_rf_ex = 1'b1; bus.branch_ex = 1'b1;
    bus.next_pc_selector_ex = 2'b01; bus.alu_operations_selector_ex = 2'b01;
    bus.rs1_data_ex = 32'h9; bus.rs2_data_ex = 32'h9;
    bus.pc_ex = 32'h40; bus.pc_plus_4_ex = 32'h44; bus.immediate_ex = 32'h10;
    issue(mk(1'b0, 32'h44, 4'b0000, 32'h12, 32'h9, 32'h44, 5'd0, 3'd0));

    // flush alone does not gate redirect
    idle(); bus.im_to_rf_ex = 1'b1; bus.rd_ex = 5'd1; bus.pc_ex = 32'h200; bus.pc_plus_4_ex = 32'h204;
    bus.immediate_ex = 32'h10; bus.next_pc_selector_ex = 2'b10; bus.flush_mem = 1'b1;
    issue(mk(1'b1, 32'h210, 4'b0000, 32'h12, 32'h9, 32'h44, 5'd0, 3'd0));

    idle();
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (rq.size() != 0 || mq.size() != 0) begin
      bad++;
      $display("FAIL queues_drained got=%0d/%0d want=0/0", rq.size(), mq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I 5-stage pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its *_ex outputs.
- Applies operand forwarding, computes the ALU result, resolves branches and jumps, and drives a PC redirect to IF.
- Registers its results into the EX/MEM pipeline register (*_mem outputs), with stall and flush control from the hazards unit.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- valid_ex  in  1  EX slot holds a real instruction (0 = bubble).
- pc_ex, pc_plus_4_ex, rs1_data_ex, rs2_data_ex, immediate_ex  in  32 each  from ID/EX.
- rd_ex  in  5  destination register.
- func_3_ex  in  3  funct3.
- func_7_bit_6_ex  in  1  funct7[5] (sub/sra select).
- im_to_rf_ex, store_ex, load_ex, branch_ex  in  1 each  control bits.
- alu_operand_a_selector_ex  in  2  00 forwarded rs1, 01 pc_ex, 10 zero, 11 zero.
- alu_operand_b_selector_ex  in  1  0 forwarded rs2, 1 immediate_ex.
- alu_operations_selector_ex  in  2  00 add, 01 branch compare, 10 R-type, 11 I-type.
- next_pc_selector_ex  in  2  00 sequential, 01 branch, 10 jal, 11 jalr.
- forward_a_sel, forward_b_sel  in  2 each  00 register data, 01 alu_result_mem, 10 wb_data, 11 register data.
- wb_data  in  32  write-back value from MEM/WB.
- stall_mem  in  1  hold the EX/MEM register.
- flush_mem  in  1  load a bubble into EX/MEM.
- redirect_valid  out  1  combinational: IF must load redirect_pc.
- redirect_pc  out  32  combinational target.
- valid_mem  out  1  registered.
- alu_result_mem, store_data_mem, pc_plus_4_mem  out  32 each  registered.
- rd_mem  out  5  registered.
- func_3_mem  out  3  registered.
- im_to_rf_mem, store_mem, load_mem  out  1 each  registered.

Behaviour:
- Reset: every *_mem output is 0 one cycle after rst is sampled high. rst overrides stall_mem and flush_mem. redirect_valid is forced 0 while rst is high.
- Forwarding: fwd_rs1 and fwd_rs2 are selected by forward_a_sel and forward_b_sel. fwd_rs2 is also the store data.
- Operand A comes from alu_operand_a_selector_ex; operand B comes from alu_operand_b_selector_ex.
- ALU op 00: A+B.
- ALU op 10, by func_3:
  - 000: add, or sub if func_7_bit_6=1.
  - 001: sll, shift amount B[4:0].
  - 010: slt (signed). 011: sltu.
  - 100: xor.
  - 101: srl, or sra if func_7_bit_6=1.
  - 110: or. 111: and.
  - All arithmetic wraps modulo 2^32; set results are 0/1 zero-extended.
- ALU op 11: same as op 10, except func_3=000 is always add.
- ALU op 01 (branch compare), taken condition by func_3:
  - 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge.
  - 010 and 011 are never taken.
  - Compare operands are fwd_rs1 vs fwd_rs2. alu_result is don't-care, registered as A+B.
- Redirect:
  - Branch (01): taken = branch_ex & compare true; target = pc_ex + immediate_ex.
  - jal (10): always; target = pc_ex + immediate_ex.
  - jalr (11): always; target = (fwd_rs1 + immediate_ex) & 0xFFFF_FFFE.
  - redirect_valid = valid_ex & !stall_mem & (taken | jal | jalr). A held instruction therefore redirects once, on its non-stalled cycle.
  - redirect_pc = target when redirect_valid, else pc_plus_4_ex.
- Link value: for jal/jalr, alu_result_mem captures pc_plus_4_ex instead of the ALU output.
- EX/MEM register update priority per edge: rst > flush_mem > stall_mem > load.
  - Flush: valid_mem, im_to_rf_mem, store_mem and load_mem go to 0; data fields hold their previous values.
  - Stall: all *_mem outputs hold.
  - Load: capture results. If valid_ex=0, capture with valid_mem, im_to_rf_mem, store_mem and load_mem all 0.
- Latency: one cycle from EX inputs to *_mem outputs; zero cycles to redirect.

Test Plan:
- Reset mid-stream: load ADD with rs1=5, rs2=7; assert rst with stall_mem=1 -> next cycle all *_mem outputs = 0, redirect_valid=0.
- R-type sweep, rs1=0xFFFF_FFF0, rs2=0x0000_0004:
  - sub -> alu_result_mem = 0xFFFF_FFEC; sra -> 0xFFFF_FFFF; srl -> 0x0FFF_FFFF; slt -> 1; sltu -> 0.
  - valid_mem = 1 and im_to_rf_mem = 1 one cycle later.
- Forwarding: rs1_data_ex=1, forward_a_sel=01 with alu_result_mem=0x100, forward_b_sel=10 with wb_data=0x20, ADD -> result 0x120. A store with the same selects -> store_data_mem = 0x20.
- Branch, pc=0x40, imm=0x10:
  - blt with -1 vs 1 -> redirect_valid=1, redirect_pc=0x50.
  - bltu with the same operands -> redirect_valid=0.
  - bne with equal operands -> redirect_valid=0.
- jalr: pc=0x80, rs1=0x1003, imm=0x4 -> redirect_pc=0x1006, alu_result_mem=0x84. With stall_mem=1 the same cycle -> redirect_valid=0 and *_mem held.
- flush_mem and stall_mem both high with a valid load -> valid_mem=0, load_mem=0 next cycle. Bubble input (valid_ex=0, branch taken) -> no redirect.
